// File: rtl/cpu_core_param_if.sv
// Program-load port and architectural status of the parametrised accumulator CPU.
interface cpu_core_param_if #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 4
);
    // Run control and program/data load port
    logic              start;
    logic              prog_we;
    logic              prog_sel;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;

    // Architectural state visible to the host
    logic [DATA_W-1:0] acc;
    logic [ADDR_W-1:0] pc;
    logic              zero;
    logic              carry;
    logic              busy;
    logic              halted;

    // Host side: issues start/program writes, observes status
    modport master (
        output start, prog_we, prog_sel, prog_addr, prog_data,
        input  acc, pc, zero, carry, busy, halted
    );

    // Core side
    modport slave (
        input  start, prog_we, prog_sel, prog_addr, prog_data,
        output acc, pc, zero, carry, busy, halted
    );
endinterface

// File: rtl/cpu_core_param.sv
// Parametrised accumulator CPU: two-word instructions (opcode, operand), on-chip
// instruction and data memories, Z/C flags, branches and halt. Each instruction
// takes FETCH_OP, FETCH_ARG and EXEC, i.e. exactly three cycles.
module cpu_core_param #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 4
) (
    input logic             clk,
    input logic             reset_n,
    cpu_core_param_if.slave bus
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH_OP  = 3'd1,
        S_FETCH_ARG = 3'd2,
        S_EXEC      = 3'd3,
        S_HALT      = 3'd4
    } state_e;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_LDA   = 4'h1,
        OP_ADD   = 4'h2,
        OP_SUB   = 4'h3,
        OP_AND   = 4'h4,
        OP_OR    = 4'h5,
        OP_XOR   = 4'h6,
        OP_XNOR  = 4'h7,
        OP_LDI   = 4'h8,
        OP_STA   = 4'h9,
        OP_JMP   = 4'hA,
        OP_JZ    = 4'hB,
        OP_JC    = 4'hC,
        OP_RSV_D = 4'hD,
        OP_RSV_E = 4'hE,
        OP_HLT   = 4'hF
    } opcode_e;

    // Architectural and control state
    state_e            state_q,   state_d;
    logic [DATA_W-1:0] acc_q,     acc_d;
    logic [ADDR_W-1:0] pc_q,      pc_d;
    opcode_e           ir_q,      ir_d;
    logic [DATA_W-1:0] operand_q, operand_d;
    logic              zero_q,    zero_d;
    logic              carry_q,   carry_d;
    logic              busy_q,    busy_d;
    logic              halted_q,  halted_d;

    // Memories (never reset; contents survive reset_n)
    logic [DATA_W-1:0] imem_q [DEPTH];
    logic [DATA_W-1:0] dmem_q [DEPTH];

    // Combinational memory read data and derived datapath values
    logic [DATA_W-1:0] imem_rd;
    logic [DATA_W-1:0] dmem_rd;
    logic [ADDR_W-1:0] target;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic              idle_or_halt;
    logic              sta_wr;

    // Memory write port controls
    logic              imem_we;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_waddr;
    logic [DATA_W-1:0] dmem_wdata;

    // Memory reads, operand address and the extra-bit ALU results for carry/borrow
    always_comb begin
        target       = ADDR_W'(operand_q);
        imem_rd      = imem_q[pc_q];
        dmem_rd      = dmem_q[target];
        sum          = {1'b0, acc_q} + {1'b0, dmem_rd};
        diff         = {1'b0, acc_q} - {1'b0, dmem_rd};
        idle_or_halt = (state_q == S_IDLE) || (state_q == S_HALT);
    end

    // State and datapath registers; async reset aborts any instruction in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            pc_q      <= '0;
            ir_q      <= OP_NOP;
            operand_q <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            operand_q <= operand_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
            busy_q    <= busy_d;
            halted_q  <= halted_d;
        end
    end

    // Next-state sequencing: start is honoured only from IDLE or HALT
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (bus.start) begin
                    state_d = S_FETCH_OP;
                end
            end
            S_FETCH_OP:  state_d = S_FETCH_ARG;
            S_FETCH_ARG: state_d = S_EXEC;
            S_EXEC:      state_d = (ir_q == OP_HLT) ? S_HALT : S_FETCH_OP;
            default:     state_d = S_IDLE;
        endcase
    end

    // Datapath: instruction fetch, operand fetch and execution
    always_comb begin
        acc_d     = acc_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        operand_d = operand_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        sta_wr    = 1'b0;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (bus.start) begin
                    pc_d = '0;
                end
            end
            S_FETCH_OP: begin
                ir_d = opcode_e'(imem_rd[3:0]);
                pc_d = pc_q + ADDR_W'(1);
            end
            S_FETCH_ARG: begin
                operand_d = imem_rd;
                pc_d      = pc_q + ADDR_W'(1);
            end
            S_EXEC: begin
                case (ir_q)
                    OP_LDA:  acc_d = dmem_rd;
                    OP_ADD:  {carry_d, acc_d} = sum;
                    OP_SUB: begin
                        acc_d   = diff[DATA_W-1:0];
                        carry_d = diff[DATA_W];
                    end
                    OP_AND:  acc_d = acc_q & dmem_rd;
                    OP_OR:   acc_d = acc_q | dmem_rd;
                    OP_XOR:  acc_d = acc_q ^ dmem_rd;
                    OP_XNOR: acc_d = ~(acc_q ^ dmem_rd);
                    OP_LDI:  acc_d = operand_q;
                    OP_STA:  sta_wr = 1'b1;
                    OP_JMP:  pc_d = target;
                    OP_JZ: begin
                        if (zero_q) begin
                            pc_d = target;
                        end
                    end
                    OP_JC: begin
                        if (carry_q) begin
                            pc_d = target;
                        end
                    end
                    default: ;
                endcase
                if (ir_q inside {[OP_LDA:OP_LDI]}) begin
                    zero_d = (acc_d == '0);
                end
            end
            default: ;
        endcase
    end

    // Registered status outputs decode the state being entered
    always_comb begin
        busy_d   = (state_d == S_FETCH_OP) || (state_d == S_FETCH_ARG) ||
                   (state_d == S_EXEC);
        halted_d = (state_d == S_HALT);
    end

    // Memory write port arbitration: host writes only while idle/halted, STA only in EXEC
    always_comb begin
        imem_we    = idle_or_halt && bus.prog_we && !bus.prog_sel;
        dmem_we    = (idle_or_halt && bus.prog_we && bus.prog_sel) || sta_wr;
        dmem_waddr = sta_wr ? target : bus.prog_addr;
        dmem_wdata = sta_wr ? acc_q  : bus.prog_data;
    end

    // Memory arrays; writes are suppressed while reset is asserted
    always_ff @(posedge clk) begin
        if (reset_n && imem_we) begin
            imem_q[bus.prog_addr] <= bus.prog_data;
        end
        if (reset_n && dmem_we) begin
            dmem_q[dmem_waddr] <= dmem_wdata;
        end
    end

    assign bus.acc    = acc_q;
    assign bus.pc     = pc_q;
    assign bus.zero   = zero_q;
    assign bus.carry  = carry_q;
    assign bus.busy   = busy_q;
    assign bus.halted = halted_q;

endmodule

// File: tb/tb_cpu_core_param.sv
// Scoreboard bench for cpu_core_param (DATA_W=4, ADDR_W=4): stimulus queues the
// hand-computed architectural state expected at each halt or probe point; a
// monitor compares whenever the core halts or a probe is requested.
module tb_cpu_core_param;

    logic clk;
    logic reset_n;
    logic probe;
    logic halted_prev;
    int   cyc;
    int   t0;
    int   vectors;
    int   miscompares;

    typedef struct {
        string      name;
        logic [3:0] acc;
        logic [3:0] pc;
        logic       zero;
        logic       carry;
        logic       busy;
        logic       halted;
        int         cycles;   // -1: cycle count not checked
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    exp_t end_e;

    cpu_core_param_if #(.DATA_W(4), .ADDR_W(4)) bus ();

    cpu_core_param #(.DATA_W(4), .ADDR_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare on each halt rising edge or explicit probe
    always @(negedge clk) begin
        if ((bus.halted && !halted_prev) || probe) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_event: got acc=%h pc=%h halted=%b, required no event",
                         bus.acc, bus.pc, bus.halted);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.acc !== mon_e.acc || bus.pc !== mon_e.pc || bus.zero !== mon_e.zero ||
                    bus.carry !== mon_e.carry || bus.busy !== mon_e.busy ||
                    bus.halted !== mon_e.halted ||
                    (mon_e.cycles >= 0 && (cyc - t0) != mon_e.cycles)) begin
                    miscompares++;
                    $display("FAIL %s: got acc=%h pc=%h z=%b c=%b busy=%b halted=%b cyc=%0d, required acc=%h pc=%h z=%b c=%b busy=%b halted=%b cyc=%0d",
                             mon_e.name, bus.acc, bus.pc, bus.zero, bus.carry, bus.busy,
                             bus.halted, cyc - t0, mon_e.acc, mon_e.pc, mon_e.zero,
                             mon_e.carry, mon_e.busy, mon_e.halted, mon_e.cycles);
                end
            end
        end
        halted_prev = bus.halted;
    end

    task automatic push_exp(input string name, input logic [3:0] a, input logic [3:0] p,
                            input logic z, input logic c, input logic b, input logic h,
                            input int n);
        exp_t e;
        e.name = name; e.acc = a; e.pc = p; e.zero = z; e.carry = c;
        e.busy = b; e.halted = h; e.cycles = n;
        exp_q.push_back(e);
    endtask

    task automatic prog_w(input logic sel, input logic [3:0] addr, input logic [3:0] data);
        bus.prog_we   = 1'b1;
        bus.prog_sel  = sel;
        bus.prog_addr = addr;
        bus.prog_data = data;
        @(posedge clk);
        #1 bus.prog_we = 1'b0;
    endtask

    // words holds n nibbles, first instruction word in the most significant nibble
    task automatic load_imem(input logic [63:0] words, input int n);
        for (int i = 0; i < n; i++) begin
            prog_w(1'b0, 4'(i), words[4*(n-1-i) +: 4]);
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        bus.start = 1'b0;
    endtask

    task automatic prog_and_start(input logic sel, input logic [3:0] addr, input logic [3:0] data);
        bus.prog_we   = 1'b1;
        bus.prog_sel  = sel;
        bus.prog_addr = addr;
        bus.prog_data = data;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        bus.prog_we = 1'b0;
        bus.start   = 1'b0;
    endtask

    task automatic do_probe();
        probe = 1'b1;
        @(negedge clk);
        #1 probe = 1'b0;
    endtask

    task automatic wait_halt(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk);
            #1;
            if (bus.halted) seen = 1'b1;
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL halt_timeout: got halted=%b after %0d cycles, required 1",
                     bus.halted, budget);
            if (exp_q.size() > 0) void'(exp_q.pop_back());
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required summary first");
        $fatal(1);
    end

    initial begin
        vectors = 0; miscompares = 0; cyc = 0; t0 = 0;
        probe = 1'b0; halted_prev = 1'b0;
        bus.start = 1'b0; bus.prog_we = 1'b0; bus.prog_sel = 1'b0;
        bus.prog_addr = '0; bus.prog_data = '0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        @(posedge clk); #1;
        push_exp("reset_state", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        do_probe();
        @(posedge clk); #1 reset_n = 1'b1;

        // Basic: 4 + 2
        prog_w(1'b1, 4'h0, 4'h4); prog_w(1'b1, 4'h1, 4'h2);
        load_imem(64'h1021F0, 6);
        push_exp("basic_add", 4'h6, 4'h6, 1'b0, 1'b0, 1'b0, 1'b1, 9);
        pulse_start(); wait_halt(100);

        // Flags: F + 1 wraps to 0 with carry
        prog_w(1'b1, 4'h0, 4'hF); prog_w(1'b1, 4'h1, 4'h1); prog_w(1'b1, 4'h2, 4'h4);
        load_imem(64'h1021F0, 6);
        push_exp("add_carry_zero", 4'h0, 4'h6, 1'b1, 1'b1, 1'b0, 1'b1, 9);
        pulse_start(); wait_halt(100);
        // 2 - 4 borrows
        load_imem(64'h8232F0, 6);
        push_exp("sub_borrow", 4'hE, 4'h6, 1'b0, 1'b1, 1'b0, 1'b1, 9);
        pulse_start(); wait_halt(100);
        // E - 1, acc kept across start, no borrow
        load_imem(64'h31F0, 4);
        push_exp("sub_no_borrow", 4'hD, 4'h4, 1'b0, 1'b0, 1'b0, 1'b1, 6);
        pulse_start(); wait_halt(100);

        // Countdown loop: LDI 3, SUB 1, JZ 8, JMP 2, HLT@8
        load_imem(64'h8331B8A2F0, 10);
        push_exp("loop_countdown", 4'h0, 4'hA, 1'b1, 1'b0, 1'b0, 1'b1, 30);
        pulse_start(); wait_halt(200);

        // Store/logic: LDI A, STA 5, LDI 0, LDA 5, XNOR 5
        load_imem(64'h8A95801575F0, 12);
        push_exp("sta_lda_xnor", 4'hF, 4'hC, 1'b0, 1'b0, 1'b0, 1'b1, 18);
        pulse_start(); wait_halt(100);
        load_imem(64'h8C45F0, 6);
        push_exp("and_C_A", 4'h8, 4'h6, 1'b0, 1'b0, 1'b0, 1'b1, 9);
        pulse_start(); wait_halt(100);
        load_imem(64'h8555F0, 6);
        push_exp("or_5_A", 4'hF, 4'h6, 1'b0, 1'b0, 1'b0, 1'b1, 9);
        pulse_start(); wait_halt(100);
        // XOR with imem[0] written on the same edge as start (preloaded as HLT)
        load_imem(64'hFA65F0, 6);
        push_exp("xor_write_with_start", 4'h0, 4'h6, 1'b1, 1'b0, 1'b0, 1'b1, 9);
        prog_and_start(1'b0, 4'h0, 4'h8); wait_halt(100);

        // Control: prog_we and start while busy are ignored
        load_imem(64'h8331B8A2F0, 10);
        pulse_start();
        repeat (5) @(posedge clk);
        #1;
        push_exp("busy_probe", 4'h3, 4'h4, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        do_probe();
        prog_and_start(1'b1, 4'h5, 4'h3);
        t0 = t0 - 6;
        push_exp("start_while_busy", 4'h0, 4'hA, 1'b1, 1'b0, 1'b0, 1'b1, 30);
        wait_halt(200);
        load_imem(64'h15F0, 4);
        push_exp("prog_while_busy", 4'hA, 4'h4, 1'b0, 1'b0, 1'b0, 1'b1, 6);
        pulse_start(); wait_halt(100);

        // pc wrap past imem[F]: JZ 4, JMP C, HLT@4, LDI 0@C, NOP@E
        load_imem(64'hB4ACF0, 6);
        prog_w(1'b0, 4'hC, 4'h8); prog_w(1'b0, 4'hD, 4'h0);
        prog_w(1'b0, 4'hE, 4'h0); prog_w(1'b0, 4'hF, 4'h0);
        push_exp("pc_wrap", 4'h0, 4'h6, 1'b1, 1'b0, 1'b0, 1'b1, 18);
        pulse_start(); wait_halt(100);
        // Restart from HALT begins at pc 0 with flags kept (JZ taken at once)
        push_exp("rerun_from_halt", 4'h0, 4'h6, 1'b1, 1'b0, 1'b0, 1'b1, 6);
        pulse_start(); wait_halt(100);

        // Async reset mid-run, then rerun gives the uninterrupted result
        prog_w(1'b1, 4'h0, 4'h4); prog_w(1'b1, 4'h1, 4'h2);
        load_imem(64'h1021F0, 6);
        pulse_start();
        repeat (4) @(posedge clk);
        #1 reset_n = 1'b0;
        push_exp("async_reset", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        do_probe();
        @(posedge clk); #1 reset_n = 1'b1;
        push_exp("restart_after_reset", 4'h6, 4'h6, 1'b0, 1'b0, 1'b0, 1'b1, 9);
        pulse_start(); wait_halt(100);

        repeat (3) @(posedge clk);
        while (exp_q.size() > 0) begin
            end_e = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL %s: got no compare event, required one", end_e.name);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
